// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one word request at a time to instruction memory,
// buffers a returned instruction while Decode stalls, and drains stale requests after a redirect.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        StallD,
   input  logic        PCSrcD,
   input  logic [31:0] PCBranchD,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic [31:0] IMemRdata,
   input  logic        IMemValid,
   output logic [31:0] InstructF,
   output logic [31:0] PCPlus4F,
   output logic        FetchValid
);

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      FULL  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] reqAddr_q, reqAddr_d;
   logic [31:0] instrBuf_q, instrBuf_d;
   logic        redirect;
   logic [31:0] pcNext;

   assign redirect = !StallD && PCSrcD;
   assign pcNext   = redirect ? PCBranchD : (pc_q + 32'd4);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      reqAddr_d  = reqAddr_q;
      instrBuf_d = instrBuf_q;
      case (state_q)
         REQ: begin
            if (IMemValid) begin
               if (StallD) begin
                  instrBuf_d = IMemRdata;
                  state_d    = FULL;
               end else begin
                  pc_d      = pcNext;
                  reqAddr_d = pcNext;
               end
            end else if (redirect) begin
               // The outstanding request cannot be cancelled; wait it out first.
               pc_d    = PCBranchD;
               state_d = DRAIN;
            end
         end
         FULL: begin
            if (!StallD) begin
               pc_d      = pcNext;
               reqAddr_d = pcNext;
               state_d   = REQ;
            end
         end
         DRAIN: begin
            if (redirect) begin
               pc_d = PCBranchD;
            end
            // Using pc_d lets a redirect arriving with the stale data still win.
            if (IMemValid) begin
               reqAddr_d = pc_d;
               state_d   = REQ;
            end
         end
         default: begin
            state_d = REQ;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q    <= REQ;
         pc_q       <= RESET_PC;
         reqAddr_q  <= RESET_PC;
         instrBuf_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         reqAddr_q  <= reqAddr_d;
         instrBuf_q <= instrBuf_d;
      end
   end

   always_comb begin
      IMemReq    = !Reset && (state_q == REQ || state_q == DRAIN);
      IMemAddr   = reqAddr_q;
      FetchValid = !Reset && ((state_q == REQ && IMemValid) || state_q == FULL);
      InstructF  = 32'd0;
      PCPlus4F   = 32'd0;
      if (FetchValid) begin
         InstructF = (state_q == FULL) ? instrBuf_q : IMemRdata;
         PCPlus4F  = pc_q + 32'd4;
      end
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 StallD  input  1  Decode stalled; presented instruction SHALL NOT be consumed this edge.
REQ-005 PCSrcD  input  1  redirect request from Decode; sampled only when StallD=0.
REQ-006 PCBranchD  input  32  redirect target PC.
REQ-007 IMemReq  output  1  instruction-memory request.
REQ-008 IMemAddr  output  32  word address of the request.
REQ-009 IMemRdata  input  32  instruction returned by memory.
REQ-010 IMemValid  input  1  IMemRdata valid; may assert in the same cycle as IMemReq (zero latency) or any later cycle.
REQ-011 InstructF  output  32  instruction to the Fetch/Decode pipeline register; 32'd0 (NOP) when FetchValid=0.
REQ-012 PCPlus4F  output  32  PC of presented instruction + 4; 32'd0 when FetchValid=0.
REQ-013 FetchValid  output  1  InstructF/PCPlus4F carry a real instruction this cycle.

Function
REQ-014 Registers SHALL be: PC (32), ReqAddr (32), InstrBuf (32), 2-bit state {REQ, FULL, DRAIN}.
REQ-015 Memory protocol: once IMemReq=1, IMemReq and IMemAddr SHALL stay constant until a cycle with IMemValid=1; requests are never cancelled.
REQ-016 REQ: IMemReq=1, IMemAddr=ReqAddr; FetchValid=IMemValid; InstructF=IMemRdata pass-through when IMemValid=1.
REQ-017 REQ, IMemValid=1, StallD=0, PCSrcD=0: consumed; PC<=PC+4, ReqAddr<=PC+4, stay REQ (one instruction per cycle sustained with zero-latency memory).
REQ-018 REQ, IMemValid=1, StallD=1: InstrBuf<=IMemRdata, go FULL.
REQ-019 REQ, IMemValid=0: stay REQ; no state change unless redirect.
REQ-020 FULL: IMemReq=0, FetchValid=1, InstructF=InstrBuf; on StallD=0 and PCSrcD=0: PC<=PC+4, ReqAddr<=PC+4, go REQ.
REQ-021 PCSrcD is sampled only when StallD=0; PCSrcD=1 while StallD=1 SHALL be ignored.
REQ-022 Redirect (StallD=0, PCSrcD=1): PC<=PCBranchD; any InstrBuf content discarded; the instruction presented that cycle counts as consumed (flushed downstream by FD Clear, not by this block).
REQ-023 Redirect in FULL, or in REQ with IMemValid=1: ReqAddr<=PCBranchD, go REQ.
REQ-024 Redirect in REQ with IMemValid=0: ReqAddr unchanged, go DRAIN.
REQ-025 DRAIN: IMemReq=1, IMemAddr=ReqAddr (old address), FetchValid=0; on IMemValid=1 discard data, ReqAddr<=PC, go REQ.
REQ-026 Redirect in DRAIN: PC<=PCBranchD, stay DRAIN; last target wins.
REQ-027 PCPlus4F SHALL equal PC+4 whenever FetchValid=1; adds wrap modulo 2^32.
REQ-028 Reset SHALL take priority over every other input in the same cycle.

Reset
REQ-029 On Reset=1 at an edge: PC<=RESET_PC, ReqAddr<=RESET_PC, InstrBuf<=0, state<=REQ.
REQ-030 While Reset=1: IMemReq=0, FetchValid=0, InstructF=0, PCPlus4F=0.
REQ-031 Reset mid-request abandons it; the instruction memory shares Reset and returns no stale IMemValid afterwards.
REQ-032 First request after reset SHALL be IMemReq=1, IMemAddr=RESET_PC, in the first cycle with Reset=0.

Verification
REQ-033 Zero-latency memory, StallD=0, PCSrcD=0, 4 cycles after reset -> IMemAddr 0,4,8,12; PCPlus4F 4,8,12,16; FetchValid=1 each cycle.
REQ-034 IMemValid delayed 3 cycles at addr 0x10 -> IMemReq/IMemAddr=0x10 held 3 cycles, FetchValid=0, InstructF=0; 4th cycle FetchValid=1, PCPlus4F=0x14.
REQ-035 Data 0x8C080004 returned with StallD=1 for 2 cycles -> FULL, IMemReq=0, InstructF=0x8C080004 held; StallD=0 -> next IMemAddr=PC+4.
REQ-036 Redirect to 0x100 while request to 0x20 outstanding -> IMemAddr stays 0x20 until IMemValid, data discarded with FetchValid=0, then IMemAddr=0x100; second redirect to 0x200 during DRAIN -> next fetch 0x200.
REQ-037 PCSrcD=1 with StallD=1 -> ignored, PC unchanged; PC=0xFFFFFFFC fetched and consumed -> PCPlus4F=0, next IMemAddr=0.
REQ-038 Reset asserted in DRAIN -> FetchValid=0, IMemReq=0 that cycle; next cycle IMemAddr=RESET_PC, state REQ.
